max7219_static_frame_loader: RTL

- Upstream stage of max7219_display_controller in static mode.
- Consumes a framed byte stream over a valid/ready interface, for example from a UART RX or host bridge.
- Packs byte pairs into 16-bit {digit_addr, seg_data} words and writes them into the controller's static RAM port (i_me_static/i_we_static/i_addr_static/i_wdata_static).
- Then presents start/last pointers with a ptr_val pulse, followed by a new_display pulse.

---
 rtl/max7219_pkg.sv | 21 ++
 rtl/max7219_loader_timeout.sv | 31 +++
 rtl/max7219_static_frame_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/max7219_pkg.sv
// Shared types and constants for the MAX7219 static frame loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: loader FSM state enum, default frame header, bytes per RAM word.
package max7219_pkg;

  // Loader FSM states, in frame order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN    = 3'd1,
    MSB    = 3'd2,
    LSB    = 3'd3,
    WR     = 3'd4,
    COMMIT = 3'd5,
    NOTIFY = 3'd6
  } t_loader_state;

  localparam logic [7:0] C_FRAME_HEADER = 8'hA5;
  localparam int         C_WORD_BYTES   = 2;

endpackage

// File: rtl/max7219_loader_timeout.sv
// Inter-byte timeout: loadable down-counter, reloaded on clr, counts while en.
// Latency: expired is combinational from the counter, so the caller acts on the same edge.
// Backpressure: none; G_TIMEOUT_CYCLES=0 disables expiry entirely.
// Ports: clk, rst_n (sync, active low), clr (reload), en (count), expired (1-cycle pulse).
module max7219_loader_timeout #(
  parameter logic [31:0] G_TIMEOUT_CYCLES = 32'd100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [31:0] remain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remain <= 32'd0;
    end else if (clr) begin
      remain <= G_TIMEOUT_CYCLES;
    end else if (en && (remain != 32'd0)) begin
      remain <= remain - 32'd1;
    end
  end

  // The edge that would take remain from 1 to 0 is the G_TIMEOUT_CYCLES-th
  // enabled edge since the reload; a reload on the same edge wins.
  assign expired = (G_TIMEOUT_CYCLES != 32'd0) && en && !clr && (remain == 32'd1);

endmodule

// File: rtl/max7219_static_frame_loader.sv
// Frame loader: packs header/len/byte-pair stream into static RAM words, then publishes pointers.
// Latency: RAM write one cycle after the LSB byte; 3 cycles per word; ptr_val 1 cycle after busy drops.
// Backpressure: o_byte_ready drops during WR/COMMIT/NOTIFY; COMMIT stalls while i_static_busy is high.
// Ports: byte stream (i_byte_valid/i_byte/o_byte_ready), i_base_ptr, i_static_busy,
//        RAM port (o_me/o_we/o_addr/o_wdata), pointers (o_start_ptr/o_last_ptr/o_ptr_val),
//        o_new_display, o_busy, o_frame_err. All outputs registered.
module max7219_static_frame_loader
  import max7219_pkg::*;
#(
  parameter int          G_RAM_ADDR_WIDTH = 8,
  parameter int          G_RAM_DATA_WIDTH = 16,
  parameter logic [7:0]  G_HEADER         = C_FRAME_HEADER,
  parameter logic [31:0] G_TIMEOUT_CYCLES = 32'd100000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_byte_valid,
  input  logic [7:0]                  i_byte,
  output logic                        o_byte_ready,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_base_ptr,
  input  logic                        i_static_busy,
  output logic                        o_me,
  output logic                        o_we,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_addr,
  output logic [G_RAM_DATA_WIDTH-1:0] o_wdata,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_start_ptr,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_last_ptr,
  output logic                        o_ptr_val,
  output logic                        o_new_display,
  output logic                        o_busy,
  output logic                        o_frame_err
);

  t_loader_state               state;
  logic [G_RAM_ADDR_WIDTH-1:0] ptr;
  logic [G_RAM_ADDR_WIDTH-1:0] start_ptr;
  logic [G_RAM_ADDR_WIDTH-1:0] last_ptr;
  logic [7:0]                  cnt;
  logic [7:0]                  word_hi;
  logic                        byte_acc;
  logic                        tmo_en;
  logic                        tmo_exp;

  assign byte_acc = i_byte_valid & o_byte_ready;
  assign tmo_en   = (state == LEN) || (state == MSB) || (state == LSB);

  max7219_loader_timeout #(
    .G_TIMEOUT_CYCLES (G_TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (byte_acc),
    .en      (tmo_en),
    .expired (tmo_exp)
  );

  // ready/busy are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      start_ptr     <= '0;
      last_ptr      <= '0;
      cnt           <= 8'd0;
      word_hi       <= 8'd0;
      o_byte_ready  <= 1'b1;
      o_me          <= 1'b0;
      o_we          <= 1'b0;
      o_addr        <= '0;
      o_wdata       <= '0;
      o_start_ptr   <= '0;
      o_last_ptr    <= '0;
      o_ptr_val     <= 1'b0;
      o_new_display <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      o_me          <= 1'b0;
      o_we          <= 1'b0;
      o_addr        <= '0;
      o_wdata       <= '0;
      o_ptr_val     <= 1'b0;
      o_new_display <= 1'b0;
      o_frame_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (byte_acc) begin
            if (i_byte == G_HEADER) begin
              ptr       <= i_base_ptr;
              start_ptr <= i_base_ptr;
              state     <= LEN;
              o_busy    <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
          end
        end

        LEN: begin
          if (byte_acc) begin
            if (i_byte == 8'd0) begin
              o_frame_err <= 1'b1;
              state       <= IDLE;
              o_busy      <= 1'b0;
            end else begin
              cnt   <= i_byte;
              state <= MSB;
            end
          end else if (tmo_exp) begin
            o_frame_err <= 1'b1;
            state       <= IDLE;
            o_busy      <= 1'b0;
          end
        end

        MSB: begin
          if (byte_acc) begin
            word_hi <= i_byte;
            state   <= LSB;
          end else if (tmo_exp) begin
            o_frame_err <= 1'b1;
            state       <= IDLE;
            o_busy      <= 1'b0;
          end
        end

        LSB: begin
          if (byte_acc) begin
            // Present the write now so it is on the RAM port for the WR cycle.
            o_me         <= 1'b1;
            o_we         <= 1'b1;
            o_addr       <= ptr;
            o_wdata      <= G_RAM_DATA_WIDTH'({word_hi, i_byte});
            state        <= WR;
            o_byte_ready <= 1'b0;
          end else if (tmo_exp) begin
            o_frame_err <= 1'b1;
            state       <= IDLE;
            o_busy      <= 1'b0;
          end
        end

        WR: begin
          ptr <= ptr + 1'b1;
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            last_ptr <= ptr;
            state    <= COMMIT;
          end else begin
            state        <= MSB;
            o_byte_ready <= 1'b1;
          end
        end

        COMMIT: begin
          if (!i_static_busy) begin
            o_ptr_val   <= 1'b1;
            o_start_ptr <= start_ptr;
            o_last_ptr  <= last_ptr;
            state       <= NOTIFY;
          end
        end

        NOTIFY: begin
          o_new_display <= 1'b1;
          state         <= IDLE;
          o_byte_ready  <= 1'b1;
          o_busy        <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          o_byte_ready <= 1'b1;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
